// File: rtl/bram_dual_port_arbiter.sv
// Four-requester arbiter in front of a dual-port BRAM: rotating priority,
// two grants per cycle, and a two-stage read-response pipeline.
module bram_dual_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              req_valid,
  output logic [3:0]              req_ready,
  input  logic [3:0]              req_write,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]              resp_valid,
  output logic [4*DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   dinb,
  output logic                    ena,
  output logic                    enb,
  output logic                    wea,
  output logic                    web,
  output logic                    regcea,
  output logic                    regceb,
  output logic                    bram_reset,
  input  logic [DATA_WIDTH-1:0]   douta,
  input  logic [DATA_WIDTH-1:0]   doutb
);

  logic [ADDR_WIDTH-1:0] addr_w  [4];
  logic [DATA_WIDTH-1:0] wdata_w [4];

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] idx;
  logic       gnt_a;
  logic       gnt_b;
  logic [1:0] id_a;
  logic [1:0] id_b;

  logic       s1a_vld_q;
  logic       s1a_vld_d;
  logic [1:0] s1a_id_q;
  logic       s1b_vld_q;
  logic       s1b_vld_d;
  logic [1:0] s1b_id_q;
  logic       s2a_vld_q;
  logic [1:0] s2a_id_q;
  logic       s2b_vld_q;
  logic [1:0] s2b_id_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_w[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_w[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan from ptr; port B skips anything that collides with port A.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    id_a  = '0;
    id_b  = '0;
    idx   = '0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr_q + 2'(j);
      if (reset && req_valid[idx]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          id_a  = idx;
        end else if (!gnt_b &&
                     !((addr_w[idx] == addr_w[id_a]) &&
                       (req_write[idx] || req_write[id_a]))) begin
          gnt_b = 1'b1;
          id_b  = idx;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_b)
      ptr_d = id_b + 2'd1;
    else if (gnt_a)
      ptr_d = id_a + 2'd1;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_a)
      req_ready[id_a] = 1'b1;
    if (gnt_b)
      req_ready[id_b] = 1'b1;
  end

  assign ena   = gnt_a;
  assign enb   = gnt_b;
  assign wea   = gnt_a & req_write[id_a];
  assign web   = gnt_b & req_write[id_b];
  assign addra = gnt_a ? addr_w[id_a]  : '0;
  assign addrb = gnt_b ? addr_w[id_b]  : '0;
  assign dina  = gnt_a ? wdata_w[id_a] : '0;
  assign dinb  = gnt_b ? wdata_w[id_b] : '0;

  assign s1a_vld_d = gnt_a & ~req_write[id_a];
  assign s1b_vld_d = gnt_b & ~req_write[id_b];

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q     <= '0;
      s1a_vld_q <= 1'b0;
      s1a_id_q  <= '0;
      s1b_vld_q <= 1'b0;
      s1b_id_q  <= '0;
      s2a_vld_q <= 1'b0;
      s2a_id_q  <= '0;
      s2b_vld_q <= 1'b0;
      s2b_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1a_vld_q <= s1a_vld_d;
      s1a_id_q  <= id_a;
      s1b_vld_q <= s1b_vld_d;
      s1b_id_q  <= id_b;
      s2a_vld_q <= s1a_vld_q;
      s2a_id_q  <= s1a_id_q;
      s2b_vld_q <= s1b_vld_q;
      s2b_id_q  <= s1b_id_q;
    end
  end

  assign regcea     = reset & s1a_vld_q;
  assign regceb     = reset & s1b_vld_q;
  assign bram_reset = ~reset;

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (reset && s2a_vld_q) begin
      resp_valid[s2a_id_q] = 1'b1;
      resp_data[int'(s2a_id_q)*DATA_WIDTH +: DATA_WIDTH] = douta;
    end
    if (reset && s2b_vld_q) begin
      resp_valid[s2b_id_q] = 1'b1;
      resp_data[int'(s2b_id_q)*DATA_WIDTH +: DATA_WIDTH] = doutb;
    end
  end

endmodule

// File: tb/tb_bram_dual_port_arbiter.sv
// Bench for bram_dual_port_arbiter: BRAM model, queue-based reference,
// directed scenarios then randomized traffic.
module tb_bram_dual_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 18;

  logic          clock;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [3:0]    req_write;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]    resp_valid;
  logic [4*DW-1:0] resp_data;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dina;
  logic [DW-1:0] dinb;
  logic          ena;
  logic          enb;
  logic          wea;
  logic          web;
  logic          regcea;
  logic          regceb;
  logic          bram_reset;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;

  bram_dual_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb),
    .ena(ena), .enb(enb),
    .wea(wea), .web(web),
    .regcea(regcea), .regceb(regceb),
    .bram_reset(bram_reset),
    .douta(douta), .doutb(doutb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 18'h1234;
    return DW'(i * 37 + 341);
  endfunction

  // BRAM: 2-cycle read latency, no-change write mode.
  logic [DW-1:0] bmem [1024];
  logic [DW-1:0] lat_a, lat_b;
  logic [DW-1:0] oreg_a, oreg_b;
  bit loaded = 1'b0;

  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) bmem[i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      if (ena) begin
        if (wea) bmem[addra] <= dina;
        else     lat_a <= bmem[addra];
      end
      if (enb) begin
        if (web) bmem[addrb] <= dinb;
        else     lat_b <= bmem[addrb];
      end
    end
    if (bram_reset)  oreg_a <= '0;
    else if (regcea) oreg_a <= lat_a;
    if (bram_reset)  oreg_b <= '0;
    else if (regceb) oreg_b <= lat_b;
  end

  assign douta = oreg_a;
  assign doutb = oreg_b;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         rq[$];
  logic [DW-1:0] ref_mem [1024];
  int            m_ptr = 0;
  int            cyc = 0;
  logic          exp_rce_a = 1'b0;
  logic          exp_rce_b = 1'b0;

  logic [3:0]    obs_ready, obs_rv;
  logic [4*DW-1:0] obs_rd;
  logic          obs_ena, obs_enb, obs_wea, obs_web;
  logic          obs_regcea, obs_regceb, obs_bram_reset;
  logic [AW-1:0] obs_addra, obs_addrb;

  function automatic logic [AW-1:0] addr_of(input int r);
    return req_addr[r*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int r);
    return req_wdata[r*DW +: DW];
  endfunction

  task automatic model_check();
    int ga, gb;
    logic [3:0] e_rdy, e_rv;
    logic [4*DW-1:0] e_rd;
    logic [AW-1:0] e_aa, e_ab;
    logic [DW-1:0] e_da, e_db;
    logic e_ena, e_enb, e_wea, e_web;
    resp_t keep[$];
    ga = -1; gb = -1;
    e_rdy = '0; e_rv = '0; e_rd = '0;
    e_aa = '0; e_ab = '0; e_da = '0; e_db = '0;
    e_ena = 1'b0; e_enb = 1'b0; e_wea = 1'b0; e_web = 1'b0;
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        int r;
        r = (m_ptr + j) % 4;
        if (req_valid[r]) begin
          if (ga < 0) ga = r;
          else if (gb < 0 &&
                   !(addr_of(r) == addr_of(ga) &&
                     (req_write[r] || req_write[ga]))) gb = r;
        end
      end
      foreach (rq[k]) if (rq[k].due == cyc) begin
        e_rv[rq[k].id] = 1'b1;
        e_rd[rq[k].id*DW +: DW] = rq[k].data;
      end
    end
    if (ga >= 0) begin
      e_rdy[ga] = 1'b1; e_ena = 1'b1; e_wea = req_write[ga];
      e_aa = addr_of(ga); e_da = wdata_of(ga);
    end
    if (gb >= 0) begin
      e_rdy[gb] = 1'b1; e_enb = 1'b1; e_web = req_write[gb];
      e_ab = addr_of(gb); e_db = wdata_of(gb);
    end
    chk("ready", req_ready, e_rdy);
    chk("ena", ena, e_ena);
    chk("enb", enb, e_enb);
    chk("wea", wea, e_wea);
    chk("web", web, e_web);
    chk("addra", addra, e_aa);
    chk("addrb", addrb, e_ab);
    chk("dina", dina, e_da);
    chk("dinb", dinb, e_db);
    chk("regcea", regcea, reset & exp_rce_a);
    chk("regceb", regceb, reset & exp_rce_b);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_data", resp_data, e_rd);
    chk("bram_reset", bram_reset, !reset);
    obs_ready = req_ready; obs_rv = resp_valid; obs_rd = resp_data;
    obs_ena = ena; obs_enb = enb; obs_wea = wea; obs_web = web;
    obs_addra = addra; obs_addrb = addrb;
    obs_regcea = regcea; obs_regceb = regceb;
    obs_bram_reset = bram_reset;
    foreach (rq[k]) if (rq[k].due > cyc) keep.push_back(rq[k]);
    rq = keep;
    if (!reset) begin
      rq.delete();
      m_ptr = 0;
      exp_rce_a = 1'b0;
      exp_rce_b = 1'b0;
    end else begin
      exp_rce_a = (ga >= 0) && !req_write[ga];
      exp_rce_b = (gb >= 0) && !req_write[gb];
      if (exp_rce_a) rq.push_back('{cyc + 2, ga, ref_mem[addr_of(ga)]});
      if (exp_rce_b) rq.push_back('{cyc + 2, gb, ref_mem[addr_of(gb)]});
      if (ga >= 0 && req_write[ga]) ref_mem[addr_of(ga)] = wdata_of(ga);
      if (gb >= 0 && req_write[gb]) ref_mem[addr_of(gb)] = wdata_of(gb);
      if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % 4;
    end
    cyc++;
  endtask

  task automatic run_cycle(input logic rst, input logic [3:0] v,
                           input logic [3:0] w, input logic [4*AW-1:0] a,
                           input logic [4*DW-1:0] d);
    @(negedge clock);
    reset = rst;
    req_valid = v;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    #4;
    model_check();
  endtask

  function automatic logic [4*AW-1:0] pack_a(input int a0, input int a1,
                                             input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic idle();
    run_cycle(1'b1, 4'h0, 4'h0, '0, '0);
  endtask

  logic [3:0] prev;
  logic [4*AW-1:0] ra;
  logic [4*DW-1:0] rd;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    reset = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) run_cycle(1'b0, 4'h0, 4'h0, '0, '0);
    chk("rst_bram_reset", obs_bram_reset, 1'b1);
    chk("rst_ready", obs_ready, 4'h0);

    run_cycle(1'b1, 4'b0100, 4'h0, pack_a(0, 0, 5, 0), '0);
    chk("lat_ready", obs_ready, 4'b0100);
    chk("lat_ena", obs_ena, 1'b1);
    chk("lat_addra", obs_addra, 10'd5);
    idle();
    chk("lat_regcea", obs_regcea, 1'b1);
    idle();
    chk("lat_rv", obs_rv, 4'b0100);
    chk("lat_rd", obs_rd[2*DW +: DW], 18'h1234);

    run_cycle(1'b0, 4'h0, 4'h0, '0, '0);
    run_cycle(1'b1, 4'hf, 4'h0, pack_a(10, 11, 12, 13), '0);
    chk("dual0_ready", obs_ready, 4'b0011);
    chk("dual0_addrb", obs_addrb, 10'd11);
    run_cycle(1'b1, 4'hf, 4'h0, pack_a(20, 21, 22, 23), '0);
    chk("dual1_ready", obs_ready, 4'b1100);
    chk("dual1_addra", obs_addra, 10'd22);
    run_cycle(1'b1, 4'hf, 4'h0, pack_a(30, 31, 32, 33), '0);
    chk("dual2_ready", obs_ready, 4'b0011);
    idle();
    idle();

    run_cycle(1'b0, 4'h0, 4'h0, '0, '0);
    run_cycle(1'b1, 4'b0111, 4'b0001, pack_a(7, 7, 9, 0),
              {54'd0, 18'h2abcd});
    chk("wc_ready", obs_ready, 4'b0101);
    chk("wc_wea", obs_wea, 1'b1);
    chk("wc_addrb", obs_addrb, 10'd9);
    run_cycle(1'b1, 4'b0010, 4'h0, pack_a(0, 7, 0, 0), '0);
    chk("wc_late_ready", obs_ready, 4'b0010);
    chk("wc_late_addra", obs_addra, 10'd7);
    idle();
    idle();
    chk("wc_rv", obs_rv, 4'b0010);
    chk("wc_rd", obs_rd[DW +: DW], 18'h2abcd);

    run_cycle(1'b0, 4'h0, 4'h0, '0, '0);
    run_cycle(1'b1, 4'b0001, 4'h0, pack_a(50, 0, 0, 0), '0);
    run_cycle(1'b1, 4'b1010, 4'h0, pack_a(0, 3, 0, 3), '0);
    chk("sa_ready", obs_ready, 4'b1010);
    idle();
    idle();
    chk("sa_rv", obs_rv, 4'b1010);
    chk("sa_rd1", obs_rd[DW +: DW], init_val(3));
    chk("sa_rd3", obs_rd[3*DW +: DW], init_val(3));

    run_cycle(1'b1, 4'b0011, 4'h0, pack_a(60, 61, 0, 0), '0);
    chk("mr_ready", obs_ready, 4'b0011);
    run_cycle(1'b0, 4'b0011, 4'h0, pack_a(60, 61, 0, 0), '0);
    chk("mr_regce", {obs_regcea, obs_regceb}, 2'b00);
    chk("mr_ena", {obs_ena, obs_enb}, 2'b00);
    chk("mr_bram_reset", obs_bram_reset, 1'b1);
    idle();
    chk("mr_rv0", obs_rv, 4'h0);
    idle();
    chk("mr_rv1", obs_rv, 4'h0);

    prev = '0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b1, 4'hf, 4'h0,
                pack_a(100 + 4*k, 101 + 4*k, 102 + 4*k, 103 + 4*k), '0);
      if (k > 0) chk("fair", prev | obs_ready, 4'hf);
      prev = obs_ready;
    end

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i*AW +: AW] = AW'($urandom_range(0, 7));
        rd[i*DW +: DW] = DW'($urandom);
      end
      run_cycle(($urandom_range(0, 39) != 0), 4'($urandom),
                4'($urandom), ra, rd);
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_dual_port_arbiter.md
BRAM_DUAL_PORT_ARBITER -- requirements
Module: bram_dual_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 18, BRAM data width.
REQ-002 Ports SHALL be:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester grant; transfer when valid&ready.
- req_write  in  4  1=write, 0=read.
- req_addr  in  4*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  4*DATA_WIDTH  write data, same packing.
- resp_valid  out  4  read data valid for requester i; no backpressure.
- resp_data  out  4*DATA_WIDTH  read data, same packing.
- addra/addrb  out  ADDR_WIDTH  BRAM port addresses.
- dina/dinb  out  DATA_WIDTH  BRAM write data.
- ena/enb, wea/web, regcea/regceb  out  1 each  BRAM enables, write enables, output-register enables.
- bram_reset  out  1  active-high BRAM output-register reset.
- douta/doutb  in  DATA_WIDTH  BRAM outputs; 2-cycle read latency, no-change write mode.

Function
REQ-003 The block SHALL share the two BRAM ports among 4 requesters, granting at most two requests per cycle.
REQ-004 A 2-bit rotating priority pointer ptr SHALL set the scan order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-005 The first valid requester in scan order SHALL be granted port A.
REQ-006 The next valid requester in scan order that does not conflict with the port-A grant SHALL be granted port B.
REQ-007 A conflict SHALL be equal addresses where at least one of the two requests is a write; two reads to the same address SHALL NOT conflict.
REQ-008 A conflicting requester SHALL be skipped, and the scan SHALL continue to later requesters for port B.
REQ-009 req_ready[i] SHALL be combinational: 1 iff requester i is granted this cycle. Requesters SHALL NOT make valid depend on ready.
REQ-010 After a cycle with at least one grant, ptr SHALL become (index of last-granted requester + 1) mod 4. After a cycle with no grant, ptr SHALL be unchanged.
REQ-011 For a port granted in cycle T, the block SHALL in cycle T:
- assert en for that port;
- drive we = req_write and addr/din from the granted requester.
For an ungranted port, en and we SHALL be 0, and addr/din SHALL be 0.
REQ-012 A read accepted in cycle T SHALL set a per-port pipeline tag (valid, requester id). In cycle T+1 the block SHALL assert regce for that port.
REQ-013 In cycle T+2 the block SHALL assert resp_valid[id] for one cycle, with resp_data[id] = dout of that port (combinational from dout).
REQ-014 Writes SHALL produce no response and no regce.
REQ-015 Two reads by the same requester granted on both ports in one cycle SHALL be impossible: each requester receives at most one grant per cycle.
REQ-016 Back-to-back grants SHALL be fully pipelined: throughput is 2 requests/cycle with no bubbles.
REQ-017 resp_valid SHALL be asserted for at most two requesters per cycle. A requester SHALL NOT receive two responses in one cycle.
REQ-018 resp_data[i] SHALL be 0 whenever resp_valid[i] = 0.

Reset
REQ-019 While reset = 0, the following SHALL hold:
- req_ready, ena/enb, wea/web, regcea/regceb, resp_valid and resp_data are 0;
- bram_reset = 1;
- ptr = 0;
- all pipeline tags are cleared.
REQ-020 Reads in flight when reset asserts SHALL be dropped: no resp_valid after reset releases.
REQ-021 In the first cycle after reset releases, arbitration SHALL resume with ptr = 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read latency: requester 2 alone reads addr 5 (preloaded 0x1234) in cycle T -> req_ready[2]=1 in T; ena=1, addra=5 in T; regcea=1 in T+1; resp_valid[2]=1, resp_data=0x1234 in T+2.
- Dual grant: all 4 valid reads, distinct addrs, ptr=0 -> requesters 0 (A) and 1 (B) granted; next cycle 2 (A) and 3 (B); ptr returns to 0.
- Write conflict: req0 writes addr 7, req1 reads addr 7, req2 reads addr 9, ptr=0 -> grants 0 (A, wea=1) and 2 (B); req1 granted next cycle and reads back the written value.
- Same-address reads: req1 and req3 read addr 3, ptr=1 -> both granted in the same cycle; both get identical resp_data two cycles later.
- Reset mid-read: reads granted in cycle T, reset=0 in T+1 -> no resp_valid in T+2 or later; all outputs 0; bram_reset=1.
- Fairness: requester 0 continuously valid with 3 other saturating requesters -> each requester granted at least once every 2 cycles.
